top_decoder: RTL and testbench



---
 rtl/top_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_top_decoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_decoder.sv
// -----------------------------------------------------------------------------
// top_decoder
//
// RV32I control decoder for the single-cycle CPU. It turns the opcode, funct3
// and funct7 fields of the current instruction into datapath controls. All
// control outputs are purely combinational. The one piece of state is a sticky
// flag that records whether any illegal encoding has been decoded since reset.
//
// Ports
//   clk          in   1  rising-edge clock; drives only the sticky flag
//   rst          in   1  synchronous, active-high reset of the sticky flag
//   Op           in   7  instruction[6:0]
//   funct3       in   3  instruction[14:12]
//   funct7       in   7  instruction[31:25]
//   RegWrite     out  1  register-file write enable
//   ALU_control  out  4  ALU operation code
//   ALUSrc       out  1  operand B select: 0 = rs2, 1 = immediate
//   MemWrite     out  1  data-memory write enable
//   ResultSrc    out  2  write-back source: 00 ALU, 01 memory, 10 PC+4
//   Branch       out  1  conditional-branch instruction
//   Jump         out  1  JAL or JALR
//   ImmSrc       out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
//   Illegal      out  1  current encoding is unsupported (combinational)
//   Illegal_seen out  1  an illegal encoding was decoded since reset (registered)
// -----------------------------------------------------------------------------
module top_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       RegWrite,
    output logic [3:0] ALU_control,
    output logic       ALUSrc,
    output logic       MemWrite,
    output logic [1:0] ResultSrc,
    output logic       Branch,
    output logic       Jump,
    output logic [2:0] ImmSrc,
    output logic       Illegal,
    output logic       Illegal_seen
);

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_XOR    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0011;
    localparam logic [3:0] ALU_SUB    = 4'b0100;
    localparam logic [3:0] ALU_SLL    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_SLT    = 4'b1000;
    localparam logic [3:0] ALU_SLTU   = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1010;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I_ALU = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shared funct3 -> ALU map for R-type and I-ALU; funct7 checks differ per
    // format and are applied by the caller.
    function automatic logic [3:0] alu_by_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000: op = alt ? ALU_SUB : ALU_ADD;
            3'b001: op = ALU_SLL;
            3'b010: op = ALU_SLT;
            3'b011: op = ALU_SLTU;
            3'b100: op = ALU_XOR;
            3'b101: op = alt ? ALU_SRA : ALU_SRL;
            3'b110: op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    logic       dec_reg_write;
    logic [3:0] dec_alu;
    logic       dec_alu_src;
    logic       dec_mem_write;
    logic [1:0] dec_result_src;
    logic       dec_branch;
    logic       dec_jump;
    logic [2:0] dec_imm_src;
    logic       dec_illegal;

    // Raw decode: fills in the controls for the opcode and raises dec_illegal
    // for bad encodings. The output stage below forces the safe defaults
    // whenever dec_illegal is set, so the raw controls need not be cleared here.
    always_comb begin
        dec_reg_write  = 1'b0;
        dec_alu        = ALU_ADD;
        dec_alu_src    = 1'b0;
        dec_mem_write  = 1'b0;
        dec_result_src = 2'b00;
        dec_branch     = 1'b0;
        dec_jump       = 1'b0;
        dec_imm_src    = 3'b000;
        dec_illegal    = 1'b0;

        case (Op)
            OP_R: begin
                dec_reg_write = 1'b1;
                // Only 000 (ADD/SUB) and 101 (SRL/SRA) accept the alternate funct7.
                if ((funct3 == 3'b000) || (funct3 == 3'b101)) begin
                    dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end else begin
                    dec_illegal = (funct7 != F7_BASE);
                end
                dec_alu = alu_by_funct3(funct3, funct7 == F7_ALT);
            end
            OP_I_ALU: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;  // no SUBI: funct7 is immediate bits
                    3'b001: begin
                        dec_illegal = (funct7 != F7_BASE);
                        dec_alu     = ALU_SLL;
                    end
                    3'b101: begin
                        dec_illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                        dec_alu     = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                    end
                    default: dec_alu = alu_by_funct3(funct3, 1'b0);
                endcase
            end
            OP_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b01;
            end
            OP_STORE: begin
                dec_alu_src   = 1'b1;
                dec_mem_write = 1'b1;
                dec_imm_src   = 3'b001;
            end
            OP_BR: begin
                dec_branch  = 1'b1;
                dec_imm_src = 3'b010;
                case (funct3[2:1])
                    2'b00:   dec_alu = ALU_SUB;
                    2'b10:   dec_alu = ALU_SLT;
                    2'b11:   dec_alu = ALU_SLTU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                dec_reg_write  = 1'b1;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
                dec_imm_src    = 3'b011;
            end
            OP_JALR: begin
                dec_reg_write  = 1'b1;
                dec_alu_src    = 1'b1;
                dec_result_src = 2'b10;
                dec_jump       = 1'b1;
            end
            OP_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm_src   = 3'b100;
                dec_alu       = ALU_PASS_B;
            end
            OP_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm_src   = 3'b100;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // An illegal encoding must never write state, so every control collapses
    // to its inert value.
    always_comb begin
        RegWrite    = dec_illegal ? 1'b0    : dec_reg_write;
        ALU_control = dec_illegal ? ALU_ADD : dec_alu;
        ALUSrc      = dec_illegal ? 1'b0    : dec_alu_src;
        MemWrite    = dec_illegal ? 1'b0    : dec_mem_write;
        ResultSrc   = dec_illegal ? 2'b00   : dec_result_src;
        Branch      = dec_illegal ? 1'b0    : dec_branch;
        Jump        = dec_illegal ? 1'b0    : dec_jump;
        ImmSrc      = dec_illegal ? 3'b000  : dec_imm_src;
        Illegal     = dec_illegal;
    end

    // Sticky flag: reset wins over a coincident illegal decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            Illegal_seen <= 1'b0;
        end else if (dec_illegal) begin
            Illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_top_decoder.sv
// -----------------------------------------------------------------------------
// tb_top_decoder
//
// Directed bench for top_decoder. Each vector packs
//   {Op[6:0], funct3[2:0], funct7[6:0], expected[14:0]}
// where expected is the hand-computed control word
//   {RegWrite, ALUSrc, MemWrite, ResultSrc[1:0], Branch, Jump,
//    ImmSrc[2:0], ALU_control[3:0], Illegal}.
// -----------------------------------------------------------------------------
module tb_top_decoder;

    logic       clk;
    logic       clk_run;
    logic       rst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       RegWrite;
    logic [3:0] ALU_control;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Branch;
    logic       Jump;
    logic [2:0] ImmSrc;
    logic       Illegal;
    logic       Illegal_seen;

    int errors;
    int checks;

    logic [14:0] obs;

    top_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .Op          (Op),
        .funct3      (funct3),
        .funct7      (funct7),
        .RegWrite    (RegWrite),
        .ALU_control (ALU_control),
        .ALUSrc      (ALUSrc),
        .MemWrite    (MemWrite),
        .ResultSrc   (ResultSrc),
        .Branch      (Branch),
        .Jump        (Jump),
        .ImmSrc      (ImmSrc),
        .Illegal     (Illegal),
        .Illegal_seen(Illegal_seen)
    );

    // ---------------- clock / reset ----------------
    // The clock stays idle until clk_run is set so the first test can show the
    // decoder responding without any edge.
    initial begin
        clk     = 1'b0;
        clk_run = 1'b0;
    end

    always #5 if (clk_run) clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        Op     = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    function automatic logic [14:0] ctrl_word();
        return {RegWrite, ALUSrc, MemWrite, ResultSrc, Branch, Jump,
                ImmSrc, ALU_control, Illegal};
    endfunction

    // ---------------- tests ----------------
    task automatic test_idle_decode();
        drive(7'b0110011, 3'b000, 7'b0000000);
        #10;
        checks++;
        if (RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL idle_regwrite: got %b expected 1", RegWrite);
        end
        checks++;
        if (ALU_control !== 4'b0011) begin
            errors++;
            $display("FAIL idle_alu: got %b expected 0011", ALU_control);
        end
        checks++;
        if (Illegal !== 1'b0) begin
            errors++;
            $display("FAIL idle_illegal: got %b expected 0", Illegal);
        end
    endtask

    task automatic test_r_type();
        logic [31:0] tbl [12] = '{
            {7'b0110011, 3'b000, 7'b0000000, 15'b1_0_0_00_0_0_000_0011_0},
            {7'b0110011, 3'b000, 7'b0100000, 15'b1_0_0_00_0_0_000_0100_0},
            {7'b0110011, 3'b001, 7'b0000000, 15'b1_0_0_00_0_0_000_0101_0},
            {7'b0110011, 3'b010, 7'b0000000, 15'b1_0_0_00_0_0_000_1000_0},
            {7'b0110011, 3'b011, 7'b0000000, 15'b1_0_0_00_0_0_000_1001_0},
            {7'b0110011, 3'b100, 7'b0000000, 15'b1_0_0_00_0_0_000_0010_0},
            {7'b0110011, 3'b101, 7'b0000000, 15'b1_0_0_00_0_0_000_0110_0},
            {7'b0110011, 3'b101, 7'b0100000, 15'b1_0_0_00_0_0_000_0111_0},
            {7'b0110011, 3'b110, 7'b0000000, 15'b1_0_0_00_0_0_000_0001_0},
            {7'b0110011, 3'b111, 7'b0000000, 15'b1_0_0_00_0_0_000_0000_0},
            {7'b0110011, 3'b001, 7'b0100000, 15'b0_0_0_00_0_0_000_0011_1},
            {7'b0110011, 3'b000, 7'b0000001, 15'b0_0_0_00_0_0_000_0011_1}
        };
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i][31:25], tbl[i][24:22], tbl[i][21:15]);
            #1;
            obs = ctrl_word();
            checks++;
            if (obs !== tbl[i][14:0]) begin
                errors++;
                $display("FAIL r_type[%0d]: got %b expected %b", i, obs, tbl[i][14:0]);
            end
        end
    endtask

    task automatic test_i_alu();
        logic [31:0] tbl [9] = '{
            {7'b0010011, 3'b000, 7'b0100000, 15'b1_1_0_00_0_0_000_0011_0},
            {7'b0010011, 3'b001, 7'b0000000, 15'b1_1_0_00_0_0_000_0101_0},
            {7'b0010011, 3'b001, 7'b0100000, 15'b0_0_0_00_0_0_000_0011_1},
            {7'b0010011, 3'b101, 7'b0000000, 15'b1_1_0_00_0_0_000_0110_0},
            {7'b0010011, 3'b101, 7'b0100000, 15'b1_1_0_00_0_0_000_0111_0},
            {7'b0010011, 3'b101, 7'b0000001, 15'b0_0_0_00_0_0_000_0011_1},
            {7'b0010011, 3'b100, 7'b1111111, 15'b1_1_0_00_0_0_000_0010_0},
            {7'b0010011, 3'b111, 7'b0101010, 15'b1_1_0_00_0_0_000_0000_0},
            {7'b0010011, 3'b011, 7'b1000000, 15'b1_1_0_00_0_0_000_1001_0}
        };
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i][31:25], tbl[i][24:22], tbl[i][21:15]);
            #1;
            obs = ctrl_word();
            checks++;
            if (obs !== tbl[i][14:0]) begin
                errors++;
                $display("FAIL i_alu[%0d]: got %b expected %b", i, obs, tbl[i][14:0]);
            end
        end
    endtask

    task automatic test_mem_jump_upper();
        logic [31:0] tbl [6] = '{
            {7'b0100011, 3'b111, 7'b1111111, 15'b0_1_1_00_0_0_001_0011_0},
            {7'b0000011, 3'b101, 7'b0100000, 15'b1_1_0_01_0_0_000_0011_0},
            {7'b1101111, 3'b010, 7'b0000001, 15'b1_0_0_10_0_1_011_0011_0},
            {7'b1100111, 3'b101, 7'b1111111, 15'b1_1_0_10_0_1_000_0011_0},
            {7'b0110111, 3'b000, 7'b0000000, 15'b1_1_0_00_0_0_100_1010_0},
            {7'b0010111, 3'b110, 7'b0100000, 15'b1_1_0_00_0_0_100_0011_0}
        };
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i][31:25], tbl[i][24:22], tbl[i][21:15]);
            #1;
            obs = ctrl_word();
            checks++;
            if (obs !== tbl[i][14:0]) begin
                errors++;
                $display("FAIL mem_jump_upper[%0d]: got %b expected %b", i, obs, tbl[i][14:0]);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] tbl [8] = '{
            {7'b1100011, 3'b000, 7'b0000000, 15'b0_0_0_00_1_0_010_0100_0},
            {7'b1100011, 3'b001, 7'b1010101, 15'b0_0_0_00_1_0_010_0100_0},
            {7'b1100011, 3'b100, 7'b0000000, 15'b0_0_0_00_1_0_010_1000_0},
            {7'b1100011, 3'b101, 7'b0000000, 15'b0_0_0_00_1_0_010_1000_0},
            {7'b1100011, 3'b110, 7'b0000000, 15'b0_0_0_00_1_0_010_1001_0},
            {7'b1100011, 3'b111, 7'b0000000, 15'b0_0_0_00_1_0_010_1001_0},
            {7'b1100011, 3'b010, 7'b0000000, 15'b0_0_0_00_0_0_000_0011_1},
            {7'b1100011, 3'b011, 7'b0000000, 15'b0_0_0_00_0_0_000_0011_1}
        };
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i][31:25], tbl[i][24:22], tbl[i][21:15]);
            #1;
            obs = ctrl_word();
            checks++;
            if (obs !== tbl[i][14:0]) begin
                errors++;
                $display("FAIL branch[%0d]: got %b expected %b", i, obs, tbl[i][14:0]);
            end
        end
    endtask

    task automatic test_unknown_op();
        logic [6:0] ops [4] = '{7'b1111111, 7'b0000000, 7'b0110001, 7'b1110011};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)));
            #1;
            obs = ctrl_word();
            checks++;
            if (obs !== 15'b0_0_0_00_0_0_000_0011_1) begin
                errors++;
                $display("FAIL unknown_op[%0d]: got %b expected %b", i, obs,
                         15'b0_0_0_00_0_0_000_0011_1);
            end
        end
    endtask

    // Inputs change on the falling edge; the flag is sampled 1 ns after each
    // rising edge.
    task automatic test_sticky();
        @(negedge clk);
        rst = 1'b1;
        drive(7'b0110011, 3'b000, 7'b0000000);
        @(posedge clk); #1;
        checks++;
        if (Illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_seen: got %b expected 0", Illegal_seen);
        end

        // Legal traffic after reset leaves the flag clear.
        @(negedge clk);
        rst = 1'b0;
        drive(7'b0010011, 3'b001, 7'b0000000);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL legal_keeps_clear: got %b expected 0", Illegal_seen);
        end

        @(negedge clk);
        drive(7'b1111111, 3'b000, 7'b0000000);
        @(posedge clk); #1;
        checks++;
        if (Illegal_seen !== 1'b1) begin
            errors++;
            $display("FAIL illegal_sets: got %b expected 1", Illegal_seen);
        end

        @(negedge clk);
        drive(7'b0000011, 3'b010, 7'b0000000);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (Illegal_seen !== 1'b1) begin
            errors++;
            $display("FAIL sticky_holds: got %b expected 1", Illegal_seen);
        end

        // Reset and illegal on the same edge: reset wins. Combinational
        // outputs still follow the inputs while rst is high.
        @(negedge clk);
        rst = 1'b1;
        drive(7'b1100011, 3'b010, 7'b0000000);
        #1;
        checks++;
        if (Illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_during_rst: got %b expected 1", Illegal);
        end
        @(posedge clk); #1;
        checks++;
        if (Illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_priority: got %b expected 0", Illegal_seen);
        end

        @(negedge clk);
        rst = 1'b0;
        drive(7'b0110111, 3'b000, 7'b0000000);
        @(posedge clk); #1;
        checks++;
        if (Illegal_seen !== 1'b0) begin
            errors++;
            $display("FAIL clear_after_rst: got %b expected 0", Illegal_seen);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        drive(7'b0000000, 3'b000, 7'b0000000);

        test_idle_decode();
        test_r_type();
        test_i_alu();
        test_mem_jump_upper();
        test_branch();
        test_unknown_op();

        clk_run = 1'b1;
        test_sticky();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
